// File: rtl/monster_unit.sv
// Single falling-and-bouncing monster: spawns on a strobe, moves once per frame,
// dies through a timed animation when hit, and frees itself on death or escape.
module monster_unit #(
  parameter int SPAWN_X      = 320,
  parameter int START_Y      = 0,
  parameter int X_STEP       = 1,
  parameter int Y_STEP       = 2,
  parameter int X_MIN        = 16,
  parameter int X_MAX        = 623,
  parameter int Y_MAX        = 479,
  parameter int DEATH_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       spawn,
  input  logic       hit,
  output logic       monster_done,
  output logic       active,
  output logic       dying,
  output logic       kill,
  output logic       escaped,
  output logic [9:0] MonsterX,
  output logic [9:0] MonsterY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DYING  = 2'd2
  } state_t;

  localparam logic [9:0]  SPAWN_X_W   = 10'(SPAWN_X);
  localparam logic [9:0]  START_Y_W   = 10'(START_Y);
  localparam logic [10:0] X_STEP_W    = 11'(X_STEP);
  localparam logic [9:0]  X_STEP_10   = 10'(X_STEP);
  localparam logic [10:0] Y_STEP_W    = 11'(Y_STEP);
  localparam logic [10:0] X_MAX_W     = 11'(X_MAX);
  localparam logic [10:0] X_MIN_PLUS  = 11'(X_MIN + X_STEP);
  localparam logic [10:0] Y_MAX_W     = 11'(Y_MAX);
  localparam logic [7:0]  DEATH_LAST  = 8'(DEATH_FRAMES - 1);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dir_left_q, dir_left_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        esc_q, esc_d;
  logic        fclk_s1_q, fclk_s2_q;
  logic        tick;
  logic [10:0] x_plus;
  logic [9:0]  x_minus;
  logic [10:0] y_plus;

  // frame_clk is sampled once, then its rising edge becomes a one-cycle tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fclk_s1_q <= 1'b0;
      fclk_s2_q <= 1'b0;
    end else begin
      fclk_s1_q <= frame_clk;
      fclk_s2_q <= fclk_s1_q;
    end
  end

  assign tick = fclk_s1_q & ~fclk_s2_q;

  // Next-state, movement and pulse generation
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_left_d = dir_left_q;
    cnt_d      = cnt_q;
    kill_d     = 1'b0;
    esc_d      = 1'b0;
    x_plus     = {1'b0, x_q} + X_STEP_W;
    x_minus    = x_q - X_STEP_10;
    y_plus     = {1'b0, y_q} + Y_STEP_W;

    case (state_q)
      ST_IDLE: begin
        if (spawn) begin
          state_d    = ST_ACTIVE;
          x_d        = SPAWN_X_W;
          y_d        = START_Y_W;
          dir_left_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // A hit takes priority over a coincident tick, so the corpse stays put
        if (hit) begin
          state_d = ST_DYING;
          kill_d  = 1'b1;
          cnt_d   = 8'd0;
        end else if (tick) begin
          if (y_plus > Y_MAX_W) begin
            state_d = ST_IDLE;
            esc_d   = 1'b1;
          end else begin
            y_d = y_plus[9:0];
            if (!dir_left_q) begin
              if (x_plus > X_MAX_W) begin
                dir_left_d = 1'b1;
                x_d        = x_minus;
              end else begin
                x_d = x_plus[9:0];
              end
            end else begin
              if ({1'b0, x_q} < X_MIN_PLUS) begin
                dir_left_d = 1'b0;
                x_d        = x_plus[9:0];
              end else begin
                x_d = x_minus;
              end
            end
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DYING: begin
        if (tick) begin
          if (cnt_q == DEATH_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_DYING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, position and pulse registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      x_q        <= SPAWN_X_W;
      y_q        <= START_Y_W;
      dir_left_q <= 1'b0;
      cnt_q      <= 8'd0;
      kill_q     <= 1'b0;
      esc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_left_q <= dir_left_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      esc_q      <= esc_d;
    end
  end

  assign monster_done = (state_q == ST_IDLE);
  assign active       = (state_q == ST_ACTIVE);
  assign dying        = (state_q == ST_DYING);
  assign kill         = kill_q;
  assign escaped      = esc_q;
  assign MonsterX     = x_q;
  assign MonsterY     = y_q;

endmodule

// File: tb/tb_monster_unit.sv
// Directed scoreboard bench for monster_unit: default instance plus a narrow
// X_MAX instance for the bounce check.
module tb_monster_unit;

  logic       clk;
  logic       rst_n;
  logic       frame_clk;
  logic       spawn;
  logic       hit;
  logic       spawn_b;
  logic       hit_b;
  logic       done, act, dyg, kill, esc;
  logic [9:0] mx, my;
  logic       done_b, act_b, dyg_b, kill_b, esc_b;
  logic [9:0] mx_b, my_b;

  int checks = 0;
  int errors = 0;
  int kill_cnt = 0;
  int esc_cnt = 0;
  bit both_seen = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  monster_unit dut (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .spawn(spawn), .hit(hit),
    .monster_done(done), .active(act), .dying(dyg), .kill(kill), .escaped(esc),
    .MonsterX(mx), .MonsterY(my)
  );

  monster_unit #(.X_MAX(325)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .spawn(spawn_b), .hit(hit_b),
    .monster_done(done_b), .active(act_b), .dying(dyg_b), .kill(kill_b), .escaped(esc_b),
    .MonsterX(mx_b), .MonsterY(my_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse monitor: counts cycles kill/escaped are high and flags overlap
  always @(negedge clk) begin
    if (kill) kill_cnt <= kill_cnt + 1;
    if (esc) esc_cnt <= esc_cnt + 1;
    if (kill && esc) both_seen <= 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic frame_tick();
    frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_spawn();
    spawn = 1'b1;
    @(negedge clk);
    spawn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_clk = 1'b0; spawn = 1'b0; hit = 1'b0;
    spawn_b = 1'b0; hit_b = 1'b0;
    repeat (3) @(negedge clk);
    push("rst_done", 32'd1); push("rst_active", 32'd0); push("rst_x", 32'd320);
    push("rst_y", 32'd0); push("rst_kill", 32'd0);
    check(32'(done)); check(32'(act)); check(32'(mx)); check(32'(my)); check(32'(kill));
    rst_n = 1'b1;

    // hit while idle must be ignored
    push("idle_hit_done", 32'd1); push("idle_hit_kills", 32'd0);
    hit = 1'b1; @(negedge clk); hit = 1'b0; @(negedge clk);
    check(32'(done)); check(32'(kill_cnt));

    // spawn both instances, first spawn after reset accepted
    push("spawn_active", 32'd1); push("spawn_done", 32'd0); push("spawn_x", 32'd320);
    spawn = 1'b1; spawn_b = 1'b1; @(negedge clk); spawn = 1'b0; spawn_b = 1'b0;
    check(32'(act)); check(32'(done)); check(32'(mx));

    for (int i = 1; i <= 5; i++) begin
      push("bounce_x_rise", 32'(320 + i));
      frame_tick();
      check(32'(mx_b));
    end
    push("bounce_x_turn", 32'd324); frame_tick(); check(32'(mx_b));
    push("bounce_x_left", 32'd323); frame_tick(); check(32'(mx_b));
    repeat (3) frame_tick();
    push("t10_active", 32'd1); push("t10_done", 32'd0);
    push("t10_x", 32'd330); push("t10_y", 32'd20);
    check(32'(act)); check(32'(done)); check(32'(mx)); check(32'(my));

    // fall to the bottom edge and escape
    repeat (229) frame_tick();
    push("t239_y", 32'd478); push("t239_active", 32'd1); push("t239_esc", 32'd0);
    check(32'(my)); check(32'(act)); check(32'(esc_cnt));
    push("esc_pulses", 32'd1); push("esc_done", 32'd1); push("esc_y", 32'd478);
    frame_tick();
    check(32'(esc_cnt)); check(32'(done)); check(32'(my));

    // hit held three cycles, landing on the same cycle as a tick
    pulse_spawn();
    repeat (5) frame_tick();
    push("pre_hit_y", 32'd10); check(32'(my));
    push("kill_pulses", 32'd1); push("hit_dying", 32'd1);
    push("hit_y", 32'd10); push("hit_x", 32'd325);
    frame_clk = 1'b1;
    @(negedge clk);
    hit = 1'b1;
    repeat (3) @(negedge clk);
    hit = 1'b0; frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    check(32'(kill_cnt)); check(32'(dyg)); check(32'(my)); check(32'(mx));
    repeat (7) frame_tick();
    push("dying_7", 32'd1); push("dying_7_y", 32'd10);
    check(32'(dyg)); check(32'(my));
    push("death_done", 32'd1); push("death_dying", 32'd0);
    frame_tick();
    check(32'(done)); check(32'(dyg));

    // spawn strobe while active is ignored
    pulse_spawn();
    repeat (5) frame_tick();
    push("respawn_y", 32'd10); push("respawn_x", 32'd325); push("respawn_active", 32'd1);
    pulse_spawn();
    @(negedge clk);
    check(32'(my)); check(32'(mx)); check(32'(act));
    push("after_ignored_y", 32'd12);
    frame_tick();
    check(32'(my));

    // reset aborts a death animation without extra pulses
    hit = 1'b1; @(negedge clk); hit = 1'b0; @(negedge clk);
    push("second_kill", 32'd2); push("second_dying", 32'd1);
    check(32'(kill_cnt)); check(32'(dyg));
    frame_tick();
    push("arst_done", 32'd1); push("arst_dying", 32'd0);
    push("arst_x", 32'd320); push("arst_y", 32'd0);
    rst_n = 1'b0;
    #1;
    check(32'(done)); check(32'(dyg)); check(32'(mx)); check(32'(my));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push("arst_kills", 32'd2); push("arst_escs", 32'd1);
    check(32'(kill_cnt)); check(32'(esc_cnt));
    push("post_rst_spawn", 32'd1);
    pulse_spawn();
    check(32'(act));
    push("kill_esc_overlap", 32'd0);
    check(32'(both_seen));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/monster_unit.md
MONSTER_UNIT -- requirements
Module: monster_unit

Interface
REQ-001 Parameter SPAWN_X, default 320, spawn X pixel column.
REQ-002 Parameter START_Y, default 0, spawn Y pixel row.
REQ-003 Parameter X_STEP, default 1, horizontal pixels per frame.
REQ-004 Parameter Y_STEP, default 2, vertical pixels per frame.
REQ-005 Parameter X_MIN / X_MAX, defaults 16 / 623, horizontal bounce limits, inclusive.
REQ-006 Parameter Y_MAX, default 479, last on-screen row.
REQ-007 Parameter DEATH_FRAMES, default 8, frames spent in the dying animation.
REQ-008 Clk  input  1  system clock, 50 MHz; all state updates on the rising edge.
REQ-009 Reset_n  input  1  asynchronous active-low reset.
REQ-010 frame_clk  input  1  vertical-sync level; its rising edge is one frame tick.
REQ-011 spawn  input  1  one-cycle spawn strobe; this unit's bit of the arbiter's one-hot select.
REQ-012 hit  input  1  bullet-collision level for this monster.
REQ-013 monster_done  output  1  high while the unit is free for respawn.
REQ-014 active  output  1  high while the monster is alive and drawn.
REQ-015 dying  output  1  high during the death animation.
REQ-016 kill  output  1  one-cycle pulse when a hit is accepted.
REQ-017 escaped  output  1  one-cycle pulse when the monster leaves the bottom of the screen.
REQ-018 MonsterX, MonsterY  output  10 each  current pixel position, unsigned.

Function
REQ-019 Frame tick SHALL be a single-Clk pulse, one cycle after frame_clk is sampled high following a sampled low.
- frame_clk is registered once; tick = current sample AND NOT previous sample.
REQ-020 The FSM SHALL have exactly three states: IDLE, ACTIVE, DYING.
- monster_done = (state == IDLE), registered.
- active = (state == ACTIVE).
- dying = (state == DYING).
REQ-021 IDLE + spawn: next cycle SHALL enter ACTIVE with X=SPAWN_X, Y=START_Y, direction=right.
REQ-022 spawn in ACTIVE or DYING SHALL be ignored with no state or position change.
REQ-023 ACTIVE + tick + no hit: horizontal move SHALL be computed in 11 bits.
- Direction right: if X+X_STEP > X_MAX, direction becomes left and X -= X_STEP; else X += X_STEP.
- Direction left: if X < X_MIN+X_STEP, direction becomes right and X += X_STEP; else X -= X_STEP.
REQ-024 ACTIVE + tick + no hit: if Y+Y_STEP > Y_MAX (11-bit compare), the unit SHALL go to IDLE.
- Pulse escaped for one cycle.
- Hold X and Y.
- Otherwise Y += Y_STEP.
REQ-025 ACTIVE + hit SHALL go to DYING next cycle.
- Pulse kill for one cycle.
- Clear the death counter.
- Freeze X and Y.
- hit wins over a simultaneous tick: no movement that cycle.
REQ-026 A hit held high across several cycles SHALL produce exactly one kill pulse.
REQ-027 hit in IDLE or DYING SHALL be ignored.
REQ-028 DYING SHALL count frame ticks.
- On the tick that brings the count to DEATH_FRAMES, go to IDLE.
- X and Y stay frozen throughout.
REQ-029 kill and escaped SHALL never be high in the same cycle.
REQ-030 Position SHALL hold in IDLE, so the sprite logic gates drawing with active OR dying.

Reset
REQ-031 Reset_n low SHALL immediately force the following, independent of Clk:
- state=IDLE, monster_done=1, active=0, dying=0, kill=0, escaped=0.
- X=SPAWN_X, Y=START_Y, direction=right.
- death counter=0, frame_clk history=0.
REQ-032 Reset asserted mid-ACTIVE or mid-DYING SHALL abort the operation with no kill or escaped pulse.
REQ-033 After Reset_n deasserts, the first spawn SHALL be accepted on the next rising Clk edge.

Verification
REQ-034 Reset, spawn pulse, 10 frame ticks -> active=1, monster_done=0, X=330, Y=20.
REQ-035 Spawn, 239 ticks -> Y=478, still ACTIVE; tick 240 -> escaped one-cycle pulse, IDLE, monster_done=1, Y=478.
REQ-036 Spawn with X_MAX overridden to 325, 6 ticks -> X sequence 321..325, then 324; direction left.
REQ-037 Spawn, 5 ticks, hit held 3 cycles coincident with a tick -> single kill pulse, Y=10 frozen, dying=1; 8 ticks later -> IDLE, monster_done=1.
REQ-038 Spawn pulse again while ACTIVE at Y=10 -> no change, Y continues to 12 on next tick.
REQ-039 Reset_n low for one cycle during DYING -> IDLE, monster_done=1, X=320, Y=0, no kill or escaped pulse; following spawn accepted.
